// File: rtl/obi_data_mem.sv
// Word-addressed OBI responder data memory: one outstanding request, byte-masked
// writes, full-word reads, configurable grant stall and response latency.
module obi_data_mem #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1,
    parameter int GNT_STALL    = 0
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        OBI_proc_req,
    input  logic        OBI_we,
    input  logic [31:0] OBI_addr,
    input  logic [31:0] OBI_wdata,
    input  logic [3:0]  OBI_be,
    output logic        OBI_mem_rdy,
    output logic        OBI_valid,
    output logic [31:0] OBI_rdata
);

    localparam int AW   = $clog2(DEPTH_WORDS);
    localparam int MAXV = (READ_LATENCY > GNT_STALL) ? READ_LATENCY : GNT_STALL;
    localparam int CW   = $clog2(MAXV + 1);

    // Loads are clamped so parameter corners never produce a negative constant.
    localparam logic [CW-1:0] BUSY_LOAD  = (READ_LATENCY >= 2) ? CW'(READ_LATENCY - 2) : '0;
    localparam logic [CW-1:0] STALL_LOAD = (GNT_STALL >= 1) ? CW'(GNT_STALL - 1) : '0;

    typedef enum logic [1:0] {IDLE, STALL, BUSY, RESP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            rdy;
    logic            hs;
    logic            we_q;
    logic [31:0]     rdata_q;
    logic [AW-1:0]   idx;
    logic [31:0]     mem [DEPTH_WORDS];

    logic unused_ok;
    assign unused_ok = ^{OBI_addr[31:AW+2], OBI_addr[1:0]};

    assign idx = OBI_addr[AW+1:2];
    assign hs  = OBI_proc_req & rdy;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (hs) begin
                we_q    <= OBI_we;
                rdata_q <= OBI_we ? 32'h0 : mem[idx];
            end
        end
    end

    // Array is never reset; a write lands on its handshake edge.
    always_ff @(posedge CLK) begin
        if (RSTn && hs && OBI_we) begin
            for (int i = 0; i < 4; i++) begin
                if (OBI_be[i]) mem[idx][8*i +: 8] <= OBI_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rdy       = 1'b0;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                rdy = (GNT_STALL == 0);
                if (OBI_proc_req) begin
                    if (rdy) begin
                        state_nxt = (READ_LATENCY == 1) ? RESP : BUSY;
                        cnt_nxt   = BUSY_LOAD;
                    end else begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_LOAD;
                    end
                end
            end
            STALL: begin
                rdy = (cnt == '0);
                if (!OBI_proc_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (rdy) begin
                    state_nxt = (READ_LATENCY == 1) ? RESP : BUSY;
                    cnt_nxt   = BUSY_LOAD;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            BUSY: begin
                if (cnt == '0) state_nxt = RESP;
                else           cnt_nxt   = cnt - CW'(1);
            end
            RESP: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign OBI_mem_rdy = rdy;
    assign OBI_valid   = (state == RESP);
    assign OBI_rdata   = (state == RESP && !we_q) ? rdata_q : 32'h0;

endmodule
